// File: rtl/dual_rail_precharge_pipe.sv
// Dual-rail (t/f) register pipeline with an internal precharge/evaluate sequencer.
// Define DRP_FAULT_DETECT_EN to build the sticky dual-rail codeword alarm.
module dual_rail_precharge_pipe #(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int PRE_CYCLES  = 1,
  parameter int EVAL_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             reset_1,
  input  logic             pc_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] Data_t,
  input  logic [WIDTH-1:0] Data_f,
  input  logic             alarm_clr,
  output logic [WIDTH-1:0] Q_t,
  output logic [WIDTH-1:0] Q_f,
  output logic             out_valid,
  output logic             phase,
  output logic             alarm
);

  // state     | meaning
  // PH_PRE    | precharge: output stage drives the 00 spacer, tokens at the tail are dropped
  // PH_EVAL   | evaluate: output stage forwards the tail stage

  localparam logic PH_PRE  = 1'b0;
  localparam logic PH_EVAL = 1'b1;

  localparam int MAXC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LAST = CW'(EVAL_CYCLES - 1);

  logic             phase_q, phase_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pc_en_q;

  logic             st_v_q [STAGES];
  logic [WIDTH-1:0] st_t_q [STAGES];
  logic [WIDTH-1:0] st_f_q [STAGES];

  logic             tail_v;
  logic [WIDTH-1:0] tail_t;
  logic [WIDTH-1:0] tail_f;

  logic [WIDTH-1:0] q_t_q;
  logic [WIDTH-1:0] q_f_q;
  logic             out_valid_q;

  assign tail_v = st_v_q[STAGES-1];
  assign tail_t = st_t_q[STAGES-1];
  assign tail_f = st_f_q[STAGES-1];

  // pc_en_q resets high so leaving reset with pc_en=1 is not seen as a restart
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (!pc_en) begin
      phase_d = PH_EVAL;
      cnt_d   = '0;
    end else if (!pc_en_q) begin
      phase_d = PH_PRE;
      cnt_d   = '0;
    end else if (phase_q == PH_PRE) begin
      if (cnt_q == PRE_LAST) begin
        phase_d = PH_EVAL;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      if (cnt_q == EVAL_LAST) begin
        phase_d = PH_PRE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset_1) begin
      phase_q <= PH_PRE;
      cnt_q   <= '0;
      pc_en_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pc_en_q <= pc_en;
    end
  end

  // Reset leaves every stage holding a logical-0 codeword (t=0, f=1), not a spacer
  always_ff @(posedge CLK) begin
    if (reset_1) begin
      for (int i = 0; i < STAGES; i++) begin
        st_v_q[i] <= 1'b0;
        st_t_q[i] <= '0;
        st_f_q[i] <= '1;
      end
    end else begin
      st_v_q[0] <= in_valid;
      st_t_q[0] <= Data_t;
      st_f_q[0] <= Data_f;
      for (int i = 1; i < STAGES; i++) begin
        st_v_q[i] <= st_v_q[i-1];
        st_t_q[i] <= st_t_q[i-1];
        st_f_q[i] <= st_f_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset_1) begin
      q_t_q       <= '0;
      q_f_q       <= '1;
      out_valid_q <= 1'b0;
    end else if (phase_q == PH_EVAL) begin
      q_t_q       <= tail_t;
      q_f_q       <= tail_f;
      out_valid_q <= tail_v;
    end else begin
      q_t_q       <= '0;
      q_f_q       <= '0;
      out_valid_q <= 1'b0;
    end
  end

  assign Q_t       = q_t_q;
  assign Q_f       = q_f_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;

`ifdef DRP_FAULT_DETECT_EN
  logic alarm_q;
  logic fault_hit;

  // A bit with t == f is a 00 or 11 pair; only judged on tokens that would be emitted
  assign fault_hit = (phase_q == PH_EVAL) && tail_v && (|(~(tail_t ^ tail_f)));

  always_ff @(posedge CLK) begin
    if (reset_1) begin
      alarm_q <= 1'b0;
    end else if (fault_hit) begin
      alarm_q <= 1'b1;
    end else if (alarm_clr) begin
      alarm_q <= 1'b0;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm_clr;
  assign unused_alarm_clr = alarm_clr;
  assign alarm            = 1'b0;
`endif

endmodule

// File: tb/tb_dual_rail_precharge_pipe.sv
// Bench for dual_rail_precharge_pipe: two instances (PRE/EVAL 1/1 with 2 stages,
// 2/3 with 3 stages) against a history-based reference model.
module tb_dual_rail_precharge_pipe;

  logic       CLK = 1'b0;
  logic       reset_1 = 1'b1;
  logic       pc_en = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] Data_t = 8'h00;
  logic [7:0] Data_f = 8'hFF;
  logic       alarm_clr = 1'b0;

  logic [7:0] qa_t, qa_f, qb_t, qb_f;
  logic       va, vb, pha, phb, ala, alb;

  always #5 CLK = ~CLK;

  dual_rail_precharge_pipe #(.WIDTH(8), .STAGES(2), .PRE_CYCLES(1), .EVAL_CYCLES(1)) dut_a (
    .CLK(CLK), .reset_1(reset_1), .pc_en(pc_en), .in_valid(in_valid),
    .Data_t(Data_t), .Data_f(Data_f), .alarm_clr(alarm_clr),
    .Q_t(qa_t), .Q_f(qa_f), .out_valid(va), .phase(pha), .alarm(ala));

  dual_rail_precharge_pipe #(.WIDTH(8), .STAGES(3), .PRE_CYCLES(2), .EVAL_CYCLES(3)) dut_b (
    .CLK(CLK), .reset_1(reset_1), .pc_en(pc_en), .in_valid(in_valid),
    .Data_t(Data_t), .Data_f(Data_f), .alarm_clr(alarm_clr),
    .Q_t(qb_t), .Q_f(qb_f), .out_valid(vb), .phase(phb), .alarm(alb));

  localparam int PM [2] = '{1, 2};
  localparam int EM [2] = '{1, 3};
  localparam int SM [2] = '{2, 3};
`ifdef DRP_FAULT_DETECT_EN
  localparam bit FD = 1'b1;
`else
  localparam bit FD = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int n = 0;

  // per-edge input history; reset edges record the reset stage contents
  bit         h_r [4096];
  bit         h_v [4096];
  logic [7:0] h_t [4096];
  logic [7:0] h_f [4096];

  // model: r counts edges since (re)start of the precharge/evaluate cycle
  int         r_m   [2];
  bit         byp_m [2];
  bit         al_m  [2];
  logic [7:0] e_qt  [2];
  logic [7:0] e_qf  [2];
  bit         e_v   [2];

  function automatic bit ph_model(int d);
    if (byp_m[d]) return 1'b1;
    return (r_m[d] % (PM[d] + EM[d])) >= PM[d];
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit         ph, rs, tv;
    logic [7:0] tt, tf;
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      ph = ph_model(d);
      rs = (n < SM[d]);
      for (int j = n - SM[d]; j < n; j++)
        if (j >= 0 && h_r[j]) rs = 1'b1;
      if (rs) begin
        tv = 1'b0; tt = 8'h00; tf = 8'hFF;
      end else begin
        tv = h_v[n-SM[d]]; tt = h_t[n-SM[d]]; tf = h_f[n-SM[d]];
      end
      if (reset_1) begin
        e_qt[d] = 8'h00; e_qf[d] = 8'hFF; e_v[d] = 1'b0;
        al_m[d] = 1'b0; r_m[d] = 0; byp_m[d] = 1'b0;
      end else begin
        if (ph) begin
          e_qt[d] = tt; e_qf[d] = tf; e_v[d] = tv;
        end else begin
          e_qt[d] = 8'h00; e_qf[d] = 8'h00; e_v[d] = 1'b0;
        end
        if (FD && ph && tv && ((~(tt ^ tf)) != 8'h00)) al_m[d] = 1'b1;
        else if (FD && alarm_clr) al_m[d] = 1'b0;
        if (!pc_en) byp_m[d] = 1'b1;
        else if (byp_m[d]) begin byp_m[d] = 1'b0; r_m[d] = 0; end
        else r_m[d] = r_m[d] + 1;
      end
    end
    h_r[n] = reset_1;
    h_v[n] = reset_1 ? 1'b0  : in_valid;
    h_t[n] = reset_1 ? 8'h00 : Data_t;
    h_f[n] = reset_1 ? 8'hFF : Data_f;
    n++;
    #1;
    check("a_qt", qa_t, e_qt[0]);
    check("a_qf", qa_f, e_qf[0]);
    check("a_valid", {7'd0, va}, {7'd0, e_v[0]});
    check("a_phase", {7'd0, pha}, {7'd0, ph_model(0)});
    check("a_alarm", {7'd0, ala}, {7'd0, al_m[0]});
    check("b_qt", qb_t, e_qt[1]);
    check("b_qf", qb_f, e_qf[1]);
    check("b_valid", {7'd0, vb}, {7'd0, e_v[1]});
    check("b_phase", {7'd0, phb}, {7'd0, ph_model(1)});
    check("b_alarm", {7'd0, alb}, {7'd0, al_m[1]});
  endtask

  task automatic idle();
    in_valid = 1'b0; Data_t = 8'h00; Data_f = 8'hFF;
  endtask

  task automatic tok(logic [7:0] t, logic [7:0] f);
    in_valid = 1'b1; Data_t = t; Data_f = f;
  endtask

  task automatic wait_phase_a(bit want);
    int k = 0;
    while (ph_model(0) != want && k < 8) begin step(); k++; end
    if (ph_model(0) != want) begin
      checks++; errors++;
      $error("FAIL wait_phase_a observed=%0d expected=%0d", ph_model(0), want);
    end
  endtask

  task automatic rand_in();
    Data_t   = 8'($urandom);
    Data_f   = ($urandom_range(7) == 0) ? 8'($urandom) : ~Data_t;
    in_valid = ($urandom_range(3) != 0);
  endtask

  initial begin
    // reset, two cycles
    reset_1 = 1'b1; idle();
    step(); step();
    check("rst_qt", qa_t, 8'h00);
    check("rst_qf", qa_f, 8'hFF);
    check("rst_valid", {7'd0, va}, 8'h00);
    check("rst_phase", {7'd0, pha}, 8'h00);
    check("rst_alarm", {7'd0, ala}, 8'h00);
    reset_1 = 1'b0;
    step();
    check("first_eval_a", {7'd0, pha}, 8'h01);

    // nominal aligned token
    wait_phase_a(1'b1);
    tok(8'hA5, 8'h5A); step();
    idle(); step();
    check("nom_pre_qt", qa_t, 8'h00);
    check("nom_pre_qf", qa_f, 8'h00);
    step();
    check("nom_qt", qa_t, 8'hA5);
    check("nom_qf", qa_f, 8'h5A);
    check("nom_valid", {7'd0, va}, 8'h01);
    step();
    check("nom_post_qt", qa_t, 8'h00);
    check("nom_post_qf", qa_f, 8'h00);
    check("nom_post_valid", {7'd0, va}, 8'h00);

    // token misaligned with evaluate is dropped, next aligned one passes
    wait_phase_a(1'b0);
    tok(8'hC3, 8'h3C); step();
    idle(); step(); step();
    check("drop_qt", qa_t, 8'h00);
    check("drop_qf", qa_f, 8'h00);
    check("drop_valid", {7'd0, va}, 8'h00);
    wait_phase_a(1'b1);
    tok(8'h3C, 8'hC3); step();
    idle(); step(); step();
    check("after_drop_qt", qa_t, 8'h3C);
    check("after_drop_qf", qa_f, 8'hC3);
    check("after_drop_valid", {7'd0, va}, 8'h01);

    // bypass: no spacers, latency STAGES+1 edges
    pc_en = 1'b0; idle(); step(); step();
    tok(8'h11, 8'hEE); step();
    check("byp_phase", {7'd0, pha}, 8'h01);
    tok(8'h22, 8'hDD); step();
    tok(8'h33, 8'hCC); step();
    check("byp_q0", qa_t, 8'h11);
    idle(); step();
    check("byp_q1", qa_t, 8'h22);
    check("byp_q1f", qa_f, 8'hDD);
    step();
    check("byp_q2", qa_t, 8'h33);
    check("byp_q2_valid", {7'd0, va}, 8'h01);
    check("byp_q2_phase", {7'd0, pha}, 8'h01);

    // codeword fault alarm
    pc_en = 1'b1; step();
    wait_phase_a(1'b1);
    tok(8'h01, 8'h01); step();
    idle(); step(); step();
    check("fault_set", {7'd0, ala}, {7'd0, FD});
    step(); step();
    check("fault_sticky", {7'd0, ala}, {7'd0, FD});
    wait_phase_a(1'b1);
    tok(8'h01, 8'h01); step();
    idle(); step();
    alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
    check("fault_set_wins", {7'd0, ala}, {7'd0, FD});
    alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
    check("fault_cleared", {7'd0, ala}, 8'h00);

    // mid-phase reset on dut_b at EVALUATE cnt=1
    for (int k = 0; k < 12 && !((r_m[1] % 5) == 3 && !byp_m[1]); k++) step();
    check("b_mid_eval", {7'd0, phb}, 8'h01);
    reset_1 = 1'b1; step();
    check("b_rst_qt", qb_t, 8'h00);
    check("b_rst_qf", qb_f, 8'hFF);
    check("b_rst_phase", {7'd0, phb}, 8'h00);
    reset_1 = 1'b0; step();
    check("b_resume1", {7'd0, phb}, 8'h00);
    step();
    check("b_resume2", {7'd0, phb}, 8'h01);

    // random traffic with the sequencer running
    for (int i = 0; i < 300; i++) begin
      rand_in();
      alarm_clr = ($urandom_range(7) == 0);
      step();
    end

    // random traffic with pc_en toggling and occasional resets
    for (int i = 0; i < 500; i++) begin
      rand_in();
      alarm_clr = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) pc_en = ~pc_en;
      reset_1 = ($urandom_range(63) == 0);
      step();
    end
    reset_1 = 1'b0; alarm_clr = 1'b0; idle(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule

// File: doc/dual_rail_precharge_pipe.md
# dual_rail_precharge_pipe

Parametrised dual-rail (t/f) register pipeline with an internal precharge/evaluate sequencer. It generalises the single-bit precharge flip-flop to WIDTH bits and STAGES sampling stages, and generates the precharge indicator internally instead of taking it as an input. The output stage emits a 00 spacer on every rail during precharge, so each evaluate transition has exactly one rising rail per bit. It sits between the AES dual-rail datapath blocks (SubBytes/MixColumns boundaries), optionally with dual-rail codeword fault detection.

## Interface
- WIDTH, 8: dual-rail bit pairs per word.
- STAGES, 2: sampling stages before the output stage, ≥1.
- PRE_CYCLES, 1: cycles per precharge phase, ≥1.
- EVAL_CYCLES, 1: cycles per evaluate phase, ≥1.
- CLK  in  1  clock; all state updates on the rising edge.
- reset_1  in  1  synchronous, active-high reset.
- pc_en  in  1  1 = run the precharge sequencer; 0 = evaluate continuously (no spacers).
- in_valid  in  1  Data_t/Data_f carry a token this cycle.
- Data_t  in  WIDTH  true rails.
- Data_f  in  WIDTH  false rails.
- alarm_clr  in  1  clears the sticky alarm.
- Q_t  out  WIDTH  true output rails, registered.
- Q_f  out  WIDTH  false output rails, registered.
- out_valid  out  1  Q carries a valid token (evaluate only).
- phase  out  1  0 = PRECHARGE, 1 = EVALUATE; registered sequencer state.
- alarm  out  1  sticky dual-rail violation flag.

## Operation
- Sampling chain: stage[0] captures {in_valid, Data_t, Data_f} every edge; stage[i] takes stage[i-1]. No stall.
- Sequencer: `phase` register plus counter `cnt` of width clog2(max(PRE_CYCLES, EVAL_CYCLES)).
  - PRECHARGE: when cnt == PRE_CYCLES-1, go to EVALUATE with cnt=0; otherwise cnt+1.
  - EVALUATE: when cnt == EVAL_CYCLES-1, go to PRECHARGE with cnt=0; otherwise cnt+1.
  - pc_en=0: the next state is EVALUATE with cnt=0 and it holds there.
  - pc_en 0→1: the next state is PRECHARGE with cnt=0, and the sequence restarts.
- Output stage, using `phase` as it stands before the edge:
  - EVALUATE: Q_t/Q_f ← tail stage rails; out_valid ← tail valid.
  - PRECHARGE: Q_t = Q_f = all-zero; out_valid ← 0.
- Tokens that reach the tail during PRECHARGE are dropped. Upstream aligns in_valid with the phase.
- Codewords are not corrected. Invalid pairs (00 or 11) pass through unchanged.
- Reset values:
  - every stage: valid=0, t=0, f=all-ones (logical 0);
  - Q_t=0, Q_f=all-ones, out_valid=0;
  - phase=0, cnt=0, alarm=0.
- Reset wins over every other input, including mid-phase and mid-token. Pipeline contents are discarded.

## Timing
- Latency: a token presented before edge k is in stage[0] after edge k and in the tail after edge k+STAGES-1. It appears on Q after edge k+STAGES only if phase=1 during the cycle before that edge.
- Period with pc_en=1 is PRE_CYCLES+EVAL_CYCLES. After reset, the first EVALUATE begins after edge PRE_CYCLES.
- With PRE=EVAL=1 and pc_en=1, phase toggles every cycle and Q alternates spacer and data.
- phase and out_valid change only on clock edges. There are no combinational paths from inputs to outputs.

## Configuration
- DRP_FAULT_DETECT_EN defined:
  - Alarm set: at any edge where phase=1 and the tail is valid, if any bit has tail_t == tail_f, alarm ← 1.
  - Alarm clear: alarm_clr=1 clears alarm on the edge.
  - Set and clear in the same cycle: set wins.
- DRP_FAULT_DETECT_EN not defined:
  - alarm is constant 0;
  - alarm_clr is ignored;
  - no comparator logic is generated.

## Test plan
- Reset: WIDTH=8. Assert reset_1 for 2 cycles → Q_t=0x00, Q_f=0xFF, out_valid=0, phase=0, alarm=0.
- Nominal: STAGES=2, PRE=EVAL=1, pc_en=1, token 0xA5 (t=0xA5, f=0x5A, valid), aligned to reach the tail during EVALUATE → Q_t=0xA5, Q_f=0x5A, out_valid=1 for one cycle. The cycles immediately before and after show Q_t=Q_f=0x00.
- Bypass: pc_en=0 with tokens 0x11, 0x22, 0x33 on consecutive cycles → same order on Q with no spacers, latency 3 edges (STAGES+1 including the output stage), phase=1 throughout.
- Fault (macro on): valid token with t=0x01, f=0x01 (bit0 = 11) in EVALUATE → alarm=1 and it stays 1. Raise alarm_clr together with a second 11 token → alarm stays 1. Clear with no fault → alarm=0. Macro off: alarm never rises.
- Mid-phase reset: PRE=2, EVAL=3. Assert reset_1 at EVALUATE cnt=1 → reset values on the next edge. First EVALUATE resumes exactly 2 edges after reset_1 deasserts.
- Dropped token: token reaches the tail during PRECHARGE → Q stays 00 and out_valid=0 for that token. The next aligned token passes unchanged.
